// File: rtl/dot_beat_sched_pkg.sv
// Shared definitions for the inner-dot beat scheduler and the selector it drives.
// Slot constants live here so both sides always agree on which beats are FC.
package dot_beat_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int CNT_MAX  = 67;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int FC_SLOT0 = 34;
    localparam int FC_SLOT1 = 50;
    localparam int FC_SLOT2 = 66;
    localparam int FC_IDX_W = 2;

    function automatic logic is_fc_slot(input logic [CW-1:0] c);
        return (c == CW'(FC_SLOT0)) || (c == CW'(FC_SLOT1)) || (c == CW'(FC_SLOT2));
    endfunction

    // Non-FC beats map to index 0 so downstream never sees a stale slot number.
    function automatic logic [FC_IDX_W-1:0] fc_slot_idx(input logic [CW-1:0] c);
        logic [FC_IDX_W-1:0] idx;
        idx = '0;
        if (c == CW'(FC_SLOT1)) idx = FC_IDX_W'(1);
        if (c == CW'(FC_SLOT2)) idx = FC_IDX_W'(2);
        return idx;
    endfunction

endpackage

// File: rtl/dot_beat_sched_tag_pipe.sv
// Latency-matched tag shift register that labels each MAC result as conv or FC.
// A flush clears every stage so nothing issued before an abort ever emerges.
module dot_tag_pipe
    import dot_beat_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IW    = FC_IDX_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_vld,
    input  logic          i_fc,
    input  logic [IW-1:0] i_idx,
    output logic          o_vld,
    output logic          o_fc,
    output logic [IW-1:0] o_idx
);

    logic [DEPTH-1:0]         r_vld;
    logic [DEPTH-1:0]         r_fc;
    logic [DEPTH-1:0][IW-1:0] r_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_fc  <= '0;
            r_idx <= '0;
        end else if (i_flush) begin
            r_vld <= '0;
            r_fc  <= '0;
            r_idx <= '0;
        end else begin
            r_vld[0] <= i_vld;
            r_fc[0]  <= i_vld & i_fc;
            r_idx[0] <= (i_vld & i_fc) ? i_idx : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_fc[k]  <= r_fc[k-1];
                r_idx[k] <= r_idx[k-1];
            end
        end
    end

    assign o_vld = r_vld[DEPTH-1];
    assign o_fc  = r_fc[DEPTH-1];
    assign o_idx = r_idx[DEPTH-1];

endmodule

// File: rtl/dot_beat_sched.sv
// Beat scheduler: walks cnt 0..CNT_MAX once per layer pass, stalling on operand
// availability, and tags each dot result as conv or FC for the accumulators.
module dot_beat_sched
    import dot_beat_sched_pkg::*;
#(
    parameter int DOT_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                src_vld,
    output logic                src_rdy,
    output logic [CW-1:0]       cnt,
    output logic                in_vld,
    output logic                res_vld_conv,
    output logic                res_vld_fc,
    output logic [FC_IDX_W-1:0] fc_idx,
    output logic                busy,
    output logic                done
);

    localparam int            DW         = (DOT_LAT > 1) ? $clog2(DOT_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DOT_LAT - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CNT_MAX);

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [DW-1:0]       r_drain;

    logic                w_accept;
    logic                w_is_fc;
    logic [FC_IDX_W-1:0] w_fc_idx;
    logic                w_tag_vld;
    logic                w_tag_fc;
    logic [FC_IDX_W-1:0] w_tag_idx;

    assign w_accept = (r_state == ST_RUN) & src_vld;

    // DRAIN waits exactly DOT_LAT cycles so the last tag leaves the pipe on its final cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_drain <= '0;
                    if (start) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (src_vld) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_drain <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DRAIN_LAST) begin
                        r_drain <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_drain <= '0;
                end
            endcase
        end
    end

    assign w_is_fc  = is_fc_slot(r_cnt);
    assign w_fc_idx = fc_slot_idx(r_cnt);

    dot_tag_pipe #(
        .DEPTH (DOT_LAT),
        .IW    (FC_IDX_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (abort),
        .i_vld   (w_accept),
        .i_fc    (w_is_fc),
        .i_idx   (w_fc_idx),
        .o_vld   (w_tag_vld),
        .o_fc    (w_tag_fc),
        .o_idx   (w_tag_idx)
    );

    assign src_rdy      = (r_state == ST_RUN);
    assign in_vld       = w_accept;
    assign cnt          = r_cnt;
    assign busy         = (r_state != ST_IDLE);
    assign res_vld_conv = w_tag_vld & ~w_tag_fc;
    assign res_vld_fc   = w_tag_vld & w_tag_fc;
    assign fc_idx       = res_vld_fc ? w_tag_idx : '0;
    assign done         = (r_state == ST_DRAIN) && (r_drain == DRAIN_LAST);

endmodule

// File: tb/tb_dot_beat_sched.sv
// Scoreboard bench for dot_beat_sched: the driver predicts each result tag when it
// issues a beat, and an independent monitor pops and compares as results appear.
module tb_dot_beat_sched;
    import dot_beat_sched_pkg::*;

    localparam int LAT = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                src_vld = 1'b0;
    logic                src_rdy;
    logic [CW-1:0]       cnt;
    logic                in_vld;
    logic                res_vld_conv;
    logic                res_vld_fc;
    logic [FC_IDX_W-1:0] fc_idx;
    logic                busy;
    logic                done;

    dot_beat_sched #(.DOT_LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .src_vld      (src_vld),
        .src_rdy      (src_rdy),
        .cnt          (cnt),
        .in_vld       (in_vld),
        .res_vld_conv (res_vld_conv),
        .res_vld_fc   (res_vld_fc),
        .fc_idx       (fc_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int due;
        bit isFc;
        int idx;
        bit last;
    } expT;

    expT expQ[$];

    int total = 0;
    int bad = 0;
    int mState = 0;
    int mCnt = 0;
    int mDrain = 0;
    int convCount, fcCount, doneCount, doneCyc, inVldCount, firstBeatCyc;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hand-derived slot map: beats 34/50/66 are FC slots 0/1/2.
    function automatic bit isFcBeat(input int c);
        return (c == 34) || (c == 50) || (c == 66);
    endfunction

    function automatic int fcIdxOf(input int c);
        if (c == 50) return 1;
        if (c == 66) return 2;
        return 0;
    endfunction

    task automatic resetCounters();
        convCount = 0; fcCount = 0; doneCount = 0; doneCyc = -1;
        inVldCount = 0; firstBeatCyc = -1;
    endtask

    // Drive one cycle: inputs set after the edge, outputs checked at the falling edge.
    task automatic applyStimulus(input bit st, input bit ab, input bit sv);
        start = st; abort = ab; src_vld = sv;
        @(negedge clk);
        checkOutput("cnt", int'(cnt), mCnt);
        checkOutput("busy", int'(busy), int'(mState != 0));
        checkOutput("src_rdy", int'(src_rdy), int'(mState == 1));
        checkOutput("in_vld", int'(in_vld), int'(mState == 1 && sv));
        checkOutput("done", int'(done), int'(mState == 2 && mDrain == LAT - 1));
        if (ab) begin
            for (int i = expQ.size() - 1; i >= 0; i--)
                if (expQ[i].due > cyc) expQ.delete(i);
            mState = 0; mCnt = 0; mDrain = 0;
        end else begin
            case (mState)
                0: if (st) mState = 1;
                1: if (sv) begin
                    expT e;
                    e.due = cyc + LAT; e.isFc = isFcBeat(mCnt);
                    e.idx = fcIdxOf(mCnt); e.last = (mCnt == 67);
                    expQ.push_back(e);
                    if (mCnt == 0) firstBeatCyc = cyc;
                    if (mCnt == 67) begin mCnt = 0; mState = 2; mDrain = 0; end
                    else mCnt++;
                end
                default: if (mDrain == LAT - 1) begin mState = 0; mDrain = 0; end
                         else mDrain++;
            endcase
        end
        @(posedge clk); #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " cnt"}, int'(cnt), 0);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " src_rdy"}, int'(src_rdy), 0);
        checkOutput({tag, " in_vld"}, int'(in_vld), 0);
        checkOutput({tag, " res_vld_conv"}, int'(res_vld_conv), 0);
        checkOutput({tag, " res_vld_fc"}, int'(res_vld_fc), 0);
        checkOutput({tag, " fc_idx"}, int'(fc_idx), 0);
        checkOutput({tag, " done"}, int'(done), 0);
    endtask

    // mode 0: no stall, 1: random stalls, 2: 5-cycle stall at cnt 50, 3: start noise
    task automatic runPass(input int mode);
        int guard;
        int stallLeft;
        bit sv;
        bit st;
        guard = 0; stallLeft = 5;
        resetCounters();
        applyStimulus(1, 0, 0);
        while (mState != 0 && guard < 2000) begin
            sv = 1'b1; st = 1'b0;
            if (mode == 1) sv = 1'($urandom_range(0, 1));
            if (mode == 2 && mState == 1 && mCnt == 50 && stallLeft > 0) begin
                sv = 1'b0; stallLeft--;
            end
            if (mode == 3 && (mState == 2 || (mState == 1 && mCnt == 10))) st = 1'b1;
            applyStimulus(st, 0, sv);
            guard++;
        end
        checkOutput("pass timeout", int'(guard < 2000), 1);
        checkOutput("beats per pass", inVldCount, 68);
        checkOutput("conv per pass", convCount, 65);
        checkOutput("fc per pass", fcCount, 3);
        checkOutput("done per pass", doneCount, 1);
        checkOutput("scoreboard drained", expQ.size(), 0);
    endtask

    always @(negedge clk) begin
        expT e;
        if (rst_n) begin
            if (in_vld) inVldCount++;
            if (res_vld_conv || res_vld_fc) begin
                checkOutput("res exclusive", int'(res_vld_conv & res_vld_fc), 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected result", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("res due cycle", cyc, e.due);
                    checkOutput("res is fc", int'(res_vld_fc), int'(e.isFc));
                    checkOutput("fc_idx", int'(fc_idx), e.isFc ? e.idx : 0);
                    checkOutput("done with last", int'(done), int'(e.last));
                end
                if (res_vld_fc) fcCount++;
                else convCount++;
            end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
                checkOutput("missing result", 0, 1);
                void'(expQ.pop_front());
            end
            if (done) begin
                doneCount++;
                doneCyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        resetCounters();
        #2;
        checkAllZero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);

        $display("[TB] no-stall pass");
        runPass(0);
        // Done lands on the 70th cycle counting the first beat as cycle 1.
        checkOutput("done offset", doneCyc - firstBeatCyc, 69);
        applyStimulus(0, 0, 0);

        $display("[TB] random-stall pass");
        runPass(1);

        $display("[TB] stall on FC slot 1");
        runPass(2);

        $display("[TB] abort at cnt 40");
        resetCounters();
        guard = 0;
        applyStimulus(1, 0, 0);
        while (mCnt != 40 && guard < 200) begin
            applyStimulus(0, 0, 1);
            guard++;
        end
        checkOutput("abort reach timeout", int'(guard < 200), 1);
        applyStimulus(0, 1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1);
        checkOutput("abort done count", doneCount, 0);
        checkOutput("abort queue empty", expQ.size(), 0);
        runPass(0);

        $display("[TB] start noise in RUN/DRAIN/done");
        runPass(3);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1);
        checkOutput("noise extra done", doneCount, 1);

        $display("[TB] start with abort in IDLE");
        applyStimulus(1, 1, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 1);

        $display("[TB] reset mid-DRAIN");
        resetCounters();
        guard = 0;
        applyStimulus(1, 0, 0);
        while (mState != 2 && guard < 200) begin
            applyStimulus(0, 0, 1);
            guard++;
        end
        checkOutput("drain reach timeout", int'(guard < 200), 1);
        rst_n = 1'b0;
        #1;
        checkAllZero("mid-drain reset");
        mState = 0; mCnt = 0; mDrain = 0;
        expQ.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1);
        checkOutput("post-reset done", doneCount, 0);
        runPass(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
